zx_io_strobe_gen: RTL and testbench

ZX_IO_STROBE_GEN -- requirements
Module: zx_io_strobe_gen

---
 rtl/zx_io_strobe_gen.sv | 181 ++++++++++++++++++
 tb/tb_zx_io_strobe_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_io_strobe_gen.sv
// zx_io_strobe_gen: turns raw, asynchronous Z80 I/O port accesses into a
// clean, fixed-length active-low bank-advance strobe (page_up_n).
// Raw bus signals are synchronized and must stay qualified for FILTER_LEN
// cycles before they count. Each accepted access fires one strobe of
// STROBE_LEN cycles. Strobes never overlap: an access that arrives while a
// strobe is still running is reported on drop_p and otherwise ignored.
module zx_io_strobe_gen #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned STROBE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       A7,
  output logic       page_up_n,
  output logic       page_up_p,
  output logic       io_active,
  output logic [7:0] access_cnt,
  output logic       glitch_p,
  output logic       drop_p
);

  localparam logic [3:0] FILT_C = 4'(FILTER_LEN);
  localparam logic [3:0] STRB_C = 4'(STROBE_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_FIRE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Synchronizer stages, bit order {iorq_n, m1_n, rd_n, wr_n, A7}
  logic [4:0] sync1_d, sync1_q;
  logic [4:0] sync2_d, sync2_q;

  state_t     state_d, state_q;
  logic [3:0] fcnt_d, fcnt_q;
  logic [3:0] scnt_d, scnt_q;
  logic [7:0] access_cnt_d, access_cnt_q;
  logic       page_up_n_d, page_up_n_q;
  logic       page_up_p_d, page_up_p_q;
  logic       io_active_d, io_active_q;
  logic       glitch_p_d, glitch_p_q;
  logic       drop_p_d, drop_p_q;

  logic iorq_s, m1_s, rd_s, wr_s, a7_s;
  logic qual_s;
  logic fire_s;

  // Synchronizer next values: first stage samples the raw pins
  always_comb begin
    sync1_d = {iorq_n, m1_n, rd_n, wr_n, A7};
    sync2_d = sync1_q;
  end

  // Decode the synchronized bus; interrupt acknowledge (m1 low) never qualifies
  always_comb begin
    {iorq_s, m1_s, rd_s, wr_s, a7_s} = sync2_q;
    qual_s = (~iorq_s) & m1_s & (~a7_s) & ((~rd_s) | (~wr_s));
  end

  // Next-state logic: filter the access, fire once, then wait for it to end
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    glitch_p_d  = 1'b0;
    drop_p_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (qual_s) begin
          if (scnt_q != 4'd0) begin
            // A strobe is still running: report and sit out this access
            drop_p_d = 1'b1;
            state_d  = ST_HOLD;
            fcnt_d   = 4'd0;
          end else if (FILT_C == 4'd1) begin
            state_d = ST_FIRE;
            fcnt_d  = 4'd0;
          end else begin
            state_d = ST_QUAL;
            fcnt_d  = 4'd1;
          end
        end else begin
          fcnt_d = 4'd0;
        end
      end
      ST_QUAL: begin
        if (qual_s) begin
          fcnt_d = fcnt_q + 4'd1;
          if ((fcnt_q + 4'd1) == FILT_C) begin
            state_d = ST_FIRE;
          end else begin
            state_d = ST_QUAL;
          end
        end else begin
          // Access vanished before the filter completed
          glitch_p_d = 1'b1;
          state_d    = ST_IDLE;
          fcnt_d     = 4'd0;
        end
      end
      ST_FIRE: begin
        state_d = ST_HOLD;
        fcnt_d  = 4'd0;
      end
      ST_HOLD: begin
        fcnt_d = 4'd0;
        if (!qual_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  // Strobe counter, access counter and registered output values
  always_comb begin
    fire_s = (state_q == ST_FIRE);
    if (fire_s) begin
      scnt_d = STRB_C;
    end else if (scnt_q != 4'd0) begin
      scnt_d = scnt_q - 4'd1;
    end else begin
      scnt_d = scnt_q;
    end
    if (fire_s && (access_cnt_q != 8'hFF)) begin
      access_cnt_d = access_cnt_q + 8'd1;
    end else begin
      access_cnt_d = access_cnt_q;
    end
    page_up_n_d = (scnt_d == 4'd0);
    page_up_p_d = (state_d == ST_FIRE);
    io_active_d = (state_d != ST_IDLE);
  end

  // All state flops; reset puts every output in its inactive level at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 5'b11111;
      sync2_q      <= 5'b11111;
      state_q      <= ST_IDLE;
      fcnt_q       <= 4'd0;
      scnt_q       <= 4'd0;
      access_cnt_q <= 8'd0;
      page_up_n_q  <= 1'b1;
      page_up_p_q  <= 1'b0;
      io_active_q  <= 1'b0;
      glitch_p_q   <= 1'b0;
      drop_p_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      scnt_q       <= scnt_d;
      access_cnt_q <= access_cnt_d;
      page_up_n_q  <= page_up_n_d;
      page_up_p_q  <= page_up_p_d;
      io_active_q  <= io_active_d;
      glitch_p_q   <= glitch_p_d;
      drop_p_q     <= drop_p_d;
    end
  end

  assign page_up_n  = page_up_n_q;
  assign page_up_p  = page_up_p_q;
  assign io_active  = io_active_q;
  assign access_cnt = access_cnt_q;
  assign glitch_p   = glitch_p_q;
  assign drop_p     = drop_p_q;

endmodule

// File: tb/tb_zx_io_strobe_gen.sv
// Testbench for zx_io_strobe_gen. Two instances share the bus inputs:
// instance 0 uses FILTER_LEN=3/STROBE_LEN=4, instance 1 FILTER_LEN=1/STROBE_LEN=15.
// Each is compared every cycle against a run-length reference model.
module tb_zx_io_strobe_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       iorq_n, m1_n, rd_n, wr_n, a7;
  logic       pun_a, pup_a, act_a, gl_a, dr_a;
  logic [7:0] cnt_a;
  logic       pun_b, pup_b, act_b, gl_b, dr_b;
  logic [7:0] cnt_b;
  logic [12:0] obs_a, obs_b;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int first_pp = -1;

  // Raw bus patterns {iorq_n, m1_n, rd_n, wr_n, A7}
  localparam logic [4:0] P_IDLE = 5'b11111;
  localparam logic [4:0] P_WR   = 5'b01100;
  localparam logic [4:0] P_INTA = 5'b00010;

  // Reference model state per instance
  int         fl [2];
  int         sl [2];
  int         mrun [2];
  bit         mwl [2];
  bit         mjf [2];
  int         msl [2];
  int         mcnt [2];
  logic [4:0] ms1 [2];
  logic [4:0] ms2 [2];
  bit         ep [2], eg [2], ed [2], eact [2];

  // Observed pulse tallies per instance
  int npp [2], ngl [2], ndr [2], nfall [2], nact [2];
  bit prev_pun [2];

  always #5 clk = ~clk;

  zx_io_strobe_gen #(.FILTER_LEN(3), .STROBE_LEN(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n),
    .wr_n(wr_n), .A7(a7), .page_up_n(pun_a), .page_up_p(pup_a), .io_active(act_a),
    .access_cnt(cnt_a), .glitch_p(gl_a), .drop_p(dr_a)
  );

  zx_io_strobe_gen #(.FILTER_LEN(1), .STROBE_LEN(15)) dut_b (
    .clk(clk), .reset_n(reset_n), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n),
    .wr_n(wr_n), .A7(a7), .page_up_n(pun_b), .page_up_p(pup_b), .io_active(act_b),
    .access_cnt(cnt_b), .glitch_p(gl_b), .drop_p(dr_b)
  );

  assign obs_a = {pun_a, pup_a, act_a, gl_a, dr_a, cnt_a};
  assign obs_b = {pun_b, pup_b, act_b, gl_b, dr_b, cnt_b};

  function automatic bit qual_f(input logic [4:0] v);
    return (v[4] == 1'b0) && (v[3] == 1'b1) && (v[0] == 1'b0) && ((v[2] == 1'b0) || (v[1] == 1'b0));
  endfunction

  task automatic mreset(input int i);
    mrun[i] = 0; mwl[i] = 1'b0; mjf[i] = 1'b0; msl[i] = 0; mcnt[i] = 0;
    ms1[i] = 5'b11111; ms2[i] = 5'b11111;
    ep[i] = 1'b0; eg[i] = 1'b0; ed[i] = 1'b0; eact[i] = 1'b0;
  endtask

  // One clock edge of the model: q is what the access filter sees this edge.
  // A run of qualifying edges either fires after fl edges, is dropped at its
  // start if a strobe is still running, or is reported as a glitch when it
  // ends early. After a fire or drop, the rest of the run is ignored (the
  // fire cycle itself ignores q), up to and including its first low edge.
  task automatic mstep(input int i, input logic [4:0] raw);
    bit q;
    bit load;
    q = qual_f(ms2[i]);
    ms2[i] = ms1[i];
    ms1[i] = raw;
    ep[i] = 1'b0; eg[i] = 1'b0; ed[i] = 1'b0;
    load = mjf[i];
    if (mjf[i]) begin
      mjf[i] = 1'b0;
      mwl[i] = 1'b1;
    end else if (mwl[i]) begin
      if (!q) mwl[i] = 1'b0;
    end else if (q) begin
      if (mrun[i] == 0 && msl[i] != 0) begin
        ed[i] = 1'b1;
        mwl[i] = 1'b1;
      end else begin
        mrun[i]++;
        if (mrun[i] >= fl[i]) begin
          ep[i] = 1'b1;
          mjf[i] = 1'b1;
          mrun[i] = 0;
        end
      end
    end else begin
      if (mrun[i] > 0) eg[i] = 1'b1;
      mrun[i] = 0;
    end
    msl[i] = load ? sl[i] : ((msl[i] > 0) ? msl[i] - 1 : 0);
    if (load && mcnt[i] < 255) mcnt[i]++;
    eact[i] = (mrun[i] > 0) || mjf[i] || mwl[i];
  endtask

  task automatic check(input int i);
    logic [12:0] o;
    logic [12:0] e;
    o = (i == 0) ? obs_a : obs_b;
    e = {(msl[i] == 0), ep[i], eact[i], eg[i], ed[i], 8'(mcnt[i])};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL model inst%0d cyc%0d: observed %b expected %b (pun,pup,act,gl,dr,cnt)", i, cyc_n, o, e);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tally(input int i, input logic [12:0] o);
    if (o[11]) npp[i]++;
    if (o[9]) ngl[i]++;
    if (o[8]) ndr[i]++;
    if (o[10]) nact[i]++;
    if (prev_pun[i] && !o[12]) nfall[i]++;
    prev_pun[i] = o[12];
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      npp[i] = 0; ngl[i] = 0; ndr[i] = 0; nfall[i] = 0; nact[i] = 0;
    end
    cyc_n = 0;
    first_pp = -1;
  endtask

  // Drive one raw pattern for one clock, then compare both instances
  task automatic cyc(input logic [4:0] raw);
    {iorq_n, m1_n, rd_n, wr_n, a7} = raw;
    @(posedge clk);
    mstep(0, raw);
    mstep(1, raw);
    #1;
    cyc_n++;
    check(0);
    check(1);
    if (pup_a && first_pp < 0) first_pp = cyc_n;
    tally(0, obs_a);
    tally(1, obs_b);
  endtask

  task automatic cycn(input logic [4:0] raw, input int n);
    for (int k = 0; k < n; k++) cyc(raw);
  endtask

  // Assert reset between clock edges and check outputs drop immediately
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, "_pun_a"}, int'(pun_a), 1);
    chk({tag, "_cnt_a"}, int'(cnt_a), 0);
    chk({tag, "_obs_b"}, int'(obs_b), int'(13'h1000));
    chk({tag, "_act_a"}, int'(act_a), 0);
    {iorq_n, m1_n, rd_n, wr_n, a7} = P_IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mreset(0);
    mreset(1);
    prev_pun[0] = 1'b1;
    prev_pun[1] = 1'b1;
    clr_counts();
  endtask

  initial begin
    logic [4:0] raw;
    int len;
    fl[0] = 3; sl[0] = 4;
    fl[1] = 1; sl[1] = 15;
    {iorq_n, m1_n, rd_n, wr_n, a7} = P_IDLE;
    reset_n = 1'b1;
    #2;
    do_reset("rst0");

    // Qualified write held 10 cycles, then idle
    cycn(P_WR, 10);
    cycn(P_IDLE, 20);
    chk("wr10_first_pp_cycle", first_pp, 5);
    chk("wr10_pp_count_a", npp[0], 1);
    chk("wr10_fall_count_a", nfall[0], 1);
    chk("wr10_cnt_a", int'(cnt_a), 1);
    chk("wr10_cnt_b", int'(cnt_b), 1);

    // Access held only 2 cycles: filtered out by instance 0
    do_reset("rst1");
    cycn(P_WR, 2);
    cycn(P_IDLE, 20);
    chk("short_glitch_a", ngl[0], 1);
    chk("short_pp_a", npp[0], 0);
    chk("short_fall_a", nfall[0], 0);
    chk("short_cnt_a", int'(cnt_a), 0);

    // Interrupt acknowledge never qualifies
    do_reset("rst2");
    cycn(P_INTA, 10);
    cycn(P_IDLE, 5);
    chk("inta_act_a", nact[0] + nact[1], 0);
    chk("inta_pp", npp[0] + npp[1], 0);
    chk("inta_glitch", ngl[0] + ngl[1], 0);
    chk("inta_cnt_b", int'(cnt_b), 0);

    // Two 6-cycle accesses 2 cycles apart
    do_reset("rst3");
    cycn(P_WR, 6);
    cycn(P_IDLE, 2);
    cycn(P_WR, 6);
    cycn(P_IDLE, 25);
    chk("pair_pp_b", npp[1], 1);
    chk("pair_drop_b", ndr[1], 1);
    chk("pair_cnt_b", int'(cnt_b), 1);
    chk("pair_pp_a", npp[0], 2);
    chk("pair_cnt_a", int'(cnt_a), 2);

    // Reset asserted mid-strobe, then a fresh access
    do_reset("rst4");
    cycn(P_WR, 7);
    chk("mid_pun_low_before_rst", int'(pun_a), 0);
    do_reset("rstmid");
    cycn(P_IDLE, 3);
    cycn(P_WR, 10);
    cycn(P_IDLE, 20);
    chk("after_rst_pp_a", npp[0], 1);
    chk("after_rst_cnt_a", int'(cnt_a), 1);

    // Randomized bus activity
    do_reset("rst5");
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 2))
          0: raw = 5'b01100;
          1: raw = 5'b01010;
          default: raw = 5'b01000;
        endcase
      end else begin
        raw = 5'($urandom);
      end
      len = $urandom_range(1, 8);
      cycn(raw, len);
      if ($urandom_range(0, 3) == 0) cycn(P_IDLE, $urandom_range(1, 18));
    end
    cycn(P_IDLE, 20);

    // 300 well-separated accesses saturate the counter
    do_reset("rst6");
    for (int s = 0; s < 300; s++) begin
      cycn(P_WR, 5);
      cycn(P_IDLE, 20);
    end
    chk("sat_fall_a", nfall[0], 300);
    chk("sat_fall_b", nfall[1], 300);
    chk("sat_cnt_a", int'(cnt_a), 255);
    chk("sat_cnt_b", int'(cnt_b), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
